// File: rtl/reg_chan_accum.sv
// reg_chan_accum: multi-channel pass/sum/accumulate/max datapath with a valid pipeline
module reg_chan_accum #(
  parameter int N = 32,
  parameter int CHANNELS = 3,
  parameter int DEPTH = 2,
  localparam int SELW = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS*N-1:0] IN_vals,
  input  logic [SELW-1:0]       IN_sel,
  input  logic [1:0]            IN_mode,
  input  logic                  IN_valid,
  input  logic                  IN_ctrl,
  output logic [N-1:0]          OUT_valA,
  output logic                  OUT_valid,
  output logic                  OUT_ovf
);
  localparam int SW = N + SELW;
  logic [N-1:0] ch [CHANNELS];
  logic [N-1:0] sel_ch, mx, acc, res;
  logic [SW-1:0] sum;
  logic [N:0] acc_sum;
  logic ovf;
  logic [N-1:0] pd [DEPTH];
  logic [DEPTH-1:0] po, pv;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch[k] = IN_vals[k*N +: N];
  end
  // out-of-range selects fall back to channel 0; max keeps the lowest index on ties
  always_comb begin
    sel_ch = ch[0];
    mx = ch[0];
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_ch = (IN_sel == SELW'(i)) ? ch[i] : sel_ch;
      mx = (ch[i] > mx) ? ch[i] : mx;
      sum = sum + SW'(ch[i]);
    end
  end
  assign acc_sum = {1'b0, acc} + {1'b0, sel_ch};
  assign res = IN_ctrl ? '0 :
               IN_mode == 2'd0 ? sel_ch :
               IN_mode == 2'd1 ? sum[N-1:0] :
               IN_mode == 2'd2 ? acc_sum[N-1:0] : mx;
  assign ovf = !IN_ctrl && (IN_mode == 2'd1 ? |sum[SW-1:N] : IN_mode == 2'd2 && acc_sum[N]);
  // accumulator moves only on accepted ACC beats; ctrl clears it instead of adding
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (IN_valid && IN_mode == 2'd2) acc <= IN_ctrl ? '0 : acc_sum[N-1:0];
  // valid bits always shift; data only advances behind a valid bit so the output holds
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv <= '0;
      po <= '0;
      for (int i = 0; i < DEPTH; i++) pd[i] <= '0;
    end else begin
      pv[0] <= IN_valid;
      if (IN_valid) begin
        pd[0] <= res;
        po[0] <= ovf;
      end
      for (int i = 1; i < DEPTH; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pd[i] <= pd[i-1];
          po[i] <= po[i-1];
        end
      end
    end
  assign OUT_valA = pd[DEPTH-1];
  assign OUT_valid = pv[DEPTH-1];
  assign OUT_ovf = po[DEPTH-1];
endmodule
